// File: rtl/dcmac_0_axis_pkt_gen_mty_pack_if.sv
// Segmented beat interface for the mty insertion stage.
// master: beat source and sink (drives i_*, i_ready; observes o_*, o_ready).
// slave : the insertion stage (observes i_*, i_ready; drives o_*, o_ready).
interface dcmac_0_axis_pkt_gen_mty_pack_if #(
  parameter int unsigned NSEG      = 12,
  parameter int unsigned SEG_BYTES = 16
);
  localparam int unsigned MW = $clog2(SEG_BYTES);
  localparam int unsigned DW = NSEG * SEG_BYTES * 8;

  logic             i_valid;
  logic             o_ready;
  logic [2:0]       i_id;
  logic [NSEG-1:0]  i_ena;
  logic [NSEG-1:0]  i_sop;
  logic [NSEG-1:0]  i_eop;
  logic [NSEG-1:0]  i_err;
  logic [NSEG*MW-1:0] i_mty;
  logic [DW-1:0]    i_dat;

  logic             o_valid;
  logic             i_ready;
  logic [2:0]       o_id;
  logic [NSEG-1:0]  o_ena;
  logic [NSEG-1:0]  o_sop;
  logic [NSEG-1:0]  o_eop;
  logic [NSEG-1:0]  o_err;
  logic [NSEG*MW-1:0] o_mty;
  logic [DW-1:0]    o_dat;
  logic             o_ovf;

  modport master (
    output i_valid, i_id, i_ena, i_sop, i_eop, i_err, i_mty, i_dat, i_ready,
    input  o_ready, o_valid, o_id, o_ena, o_sop, o_eop, o_err, o_mty, o_dat, o_ovf
  );

  modport slave (
    input  i_valid, i_id, i_ena, i_sop, i_eop, i_err, i_mty, i_dat, i_ready,
    output o_ready, o_valid, o_id, o_ena, o_sop, o_eop, o_err, o_mty, o_dat, o_ovf
  );
endinterface

// File: rtl/dcmac_0_axis_pkt_gen_mty_pack.sv
// Empty-byte insertion stage: every EOP segment (below the last segment)
// with nonzero mty pushes all later segment data up by mty bytes, so the
// following SOP lands on a segment boundary. Two-stage pipeline with a
// shared enable; S1 captures the beat and computes per-segment gaps, S2
// applies a bounded per-segment byte shift.
// Ports: clk, rst (sync, active-high), bus (slave modport: i_* beat in with
// i_valid/o_ready, o_* beat out with o_valid/i_ready, o_ovf overflow flag).
module dcmac_0_axis_pkt_gen_mty_pack #(
  parameter int unsigned NSEG      = 12,
  parameter int unsigned SEG_BYTES = 16,
  parameter int unsigned MAX_EOP   = 3
) (
  input  logic clk,
  input  logic rst,
  dcmac_0_axis_pkt_gen_mty_pack_if.slave bus
);
  localparam int unsigned MW    = $clog2(SEG_BYTES);
  localparam int unsigned SBITS = SEG_BYTES * 8;
  localparam int unsigned DW    = NSEG * SBITS;
  localparam int unsigned GW    = $clog2(MAX_EOP * (SEG_BYTES - 1) + 1);
  localparam int unsigned CW    = $clog2(NSEG + 1);

  logic en;

  // Whole pipeline advances together; holds only when the output is blocked.
  assign en          = bus.i_ready | ~bus.o_valid;
  assign bus.o_ready = en | rst;

  // Per-segment gap: running sum of mty of the first MAX_EOP enabled EOPs
  // strictly below this segment; the last segment never contributes.
  logic [GW-1:0] gap_c [NSEG];
  logic          ovf_c;

  always_comb begin
    logic [CW-1:0] cnt;
    logic [GW-1:0] acc;
    cnt = '0;
    acc = '0;
    for (int i = 0; i < NSEG; i++) begin
      gap_c[i] = acc;
      if ((i < int'(NSEG) - 1) && bus.i_ena[i] && bus.i_eop[i]) begin
        if (cnt < CW'(MAX_EOP)) acc = acc + GW'(bus.i_mty[i*MW +: MW]);
        cnt = cnt + CW'(1);
      end
    end
    ovf_c = (cnt > CW'(MAX_EOP));
  end

  // S1: beat capture plus computed gaps.
  logic                s1_valid;
  logic [2:0]          s1_id;
  logic [NSEG-1:0]     s1_ena, s1_sop, s1_eop, s1_err;
  logic [NSEG*MW-1:0]  s1_mty;
  logic [DW-1:0]       s1_dat;
  logic [GW-1:0]       s1_gap [NSEG];
  logic                s1_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_ena   <= '0;
      s1_sop   <= '0;
      s1_eop   <= '0;
      s1_err   <= '0;
      s1_mty   <= '0;
      s1_dat   <= '0;
      s1_ovf   <= 1'b0;
      for (int i = 0; i < NSEG; i++) s1_gap[i] <= '0;
    end else if (en) begin
      s1_valid <= bus.i_valid;
      s1_id    <= bus.i_id;
      s1_ena   <= bus.i_ena;
      s1_sop   <= bus.i_sop;
      s1_eop   <= bus.i_eop;
      s1_err   <= bus.i_err;
      s1_mty   <= bus.i_mty;
      s1_dat   <= bus.i_dat;
      s1_ovf   <= ovf_c;
      for (int i = 0; i < NSEG; i++) s1_gap[i] <= gap_c[i];
    end
  end

  // Per-segment shifter: segment g can only pull from at most SPAN bytes
  // below its own base, so each shifter sees just that window.
  logic [DW-1:0] shf_c;

  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    localparam int SPAN = ((g < int'(MAX_EOP)) ? g : int'(MAX_EOP)) * (int'(SEG_BYTES) - 1);
    localparam int WB   = SPAN + int'(SEG_BYTES);

    logic [WB*8-1:0]  win;
    logic [SBITS-1:0] seg;

    assign win = s1_dat[(g*int'(SEG_BYTES) - SPAN)*8 +: WB*8];

    // Output byte b comes from window byte b + SPAN - gap.
    always_comb begin
      seg = '0;
      for (int b = 0; b < int'(SEG_BYTES); b++)
        seg[b*8 +: 8] = win[(b + SPAN - int'(s1_gap[g]))*8 +: 8];
    end

    assign shf_c[g*SBITS +: SBITS] = seg;
  end

  // S2: registered outputs; an overflowing beat flags every enabled segment.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.o_valid <= 1'b0;
      bus.o_id    <= '0;
      bus.o_ena   <= '0;
      bus.o_sop   <= '0;
      bus.o_eop   <= '0;
      bus.o_err   <= '0;
      bus.o_mty   <= '0;
      bus.o_dat   <= '0;
      bus.o_ovf   <= 1'b0;
    end else if (en) begin
      bus.o_valid <= s1_valid;
      bus.o_id    <= s1_id;
      bus.o_ena   <= s1_ena;
      bus.o_sop   <= s1_sop;
      bus.o_eop   <= s1_eop;
      bus.o_err   <= s1_err | (s1_ena & {NSEG{s1_ovf}});
      bus.o_mty   <= s1_mty;
      bus.o_dat   <= shf_c;
      bus.o_ovf   <= s1_valid & s1_ovf;
    end
  end
endmodule

// File: tb/tb_dcmac_0_axis_pkt_gen_mty_pack.sv
module tb_dcmac_0_axis_pkt_gen_mty_pack;
  localparam int unsigned NSEG    = 12;
  localparam int unsigned SB      = 16;
  localparam int unsigned MAX_EOP = 3;
  localparam int unsigned MW      = 4;
  localparam int unsigned NB      = NSEG * SB;
  localparam int unsigned DW      = NB * 8;
  localparam int          NT      = 8;

  typedef struct {
    logic [2:0]         id;
    logic [NSEG-1:0]    ena, sop, eop, err;
    logic [NSEG*MW-1:0] mty;
    logic [DW-1:0]      dat;
  } beat_t;

  typedef struct {
    beat_t b;
    logic  ovf;
    int    cyc;
  } exp_t;

  typedef struct {
    logic [NSEG-1:0]    ena, sop, eop, err, exp_err;
    logic [NSEG*MW-1:0] mty;
    int                 gap [NSEG];
    logic               exp_ovf;
  } vec_t;

  logic clk;
  logic rst;

  dcmac_0_axis_pkt_gen_mty_pack_if #(.NSEG(NSEG), .SEG_BYTES(SB)) bus ();

  dcmac_0_axis_pkt_gen_mty_pack #(.NSEG(NSEG), .SEG_BYTES(SB), .MAX_EOP(MAX_EOP)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec, n_bad, cyc;
  bit   chk_lat, rand_rdy, stall_prev, acc_flag;
  exp_t sb_q[$];
  exp_t cur_exp;
  logic [2:0] next_id;
  vec_t vt [NT];

  logic [52:0]        snap_ctl;
  logic [NSEG*MW-1:0] snap_mty;
  logic [DW-1:0]      snap_dat;

  function automatic logic [NSEG*MW-1:0] m1(input int s, input int v);
    logic [NSEG*MW-1:0] r;
    r = '0;
    r[s*MW +: MW] = MW'(v);
    return r;
  endfunction

  // Output byte a of segment s is input byte a - gap[s].
  function automatic logic [DW-1:0] shift_dat(input logic [DW-1:0] d, input int g [NSEG]);
    logic [DW-1:0] r;
    r = '0;
    for (int s = 0; s < NSEG; s++)
      for (int b = 0; b < SB; b++) begin
        int a;
        a = s * SB + b;
        r[a*8 +: 8] = d[(a - g[s])*8 +: 8];
      end
    return r;
  endfunction

  function automatic logic [DW-1:0] dmask(input beat_t b);
    logic [DW-1:0] m;
    m = '0;
    for (int s = 0; s < NSEG; s++)
      for (int k = 0; k < SB; k++) begin
        int lim;
        lim = SB - (b.eop[s] ? int'(b.mty[s*MW +: MW]) : 0);
        if (b.ena[s] && k < lim) m[(s*SB + k)*8 +: 8] = 8'hFF;
      end
    return m;
  endfunction

  task automatic model(input beat_t b, output exp_t e);
    int   g [NSEG];
    int   n, acc;
    logic ovf;
    n = 0;
    acc = 0;
    for (int s = 0; s < NSEG; s++) begin
      g[s] = acc;
      if (s < NSEG - 1 && b.ena[s] && b.eop[s]) begin
        n++;
        if (n <= MAX_EOP) acc += int'(b.mty[s*MW +: MW]);
      end
    end
    ovf = (n > MAX_EOP);
    e.b = b;
    e.b.dat = shift_dat(b.dat, g);
    e.b.err = b.err | (ovf ? b.ena : '0);
    e.ovf = ovf;
    e.cyc = 0;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_dat(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp,
                         input logic [DW-1:0] m);
    int bad;
    bad = -1;
    n_vec++;
    for (int k = NB - 1; k >= 0; k--)
      if ((act[k*8 +: 8] & m[k*8 +: 8]) !== (exp[k*8 +: 8] & m[k*8 +: 8])) bad = k;
    if (bad >= 0) begin
      n_bad++;
      $display("FAIL %s: byte %0d got 0x%0h expected 0x%0h (t=%0t)", nm, bad,
               act[bad*8 +: 8], exp[bad*8 +: 8], $time);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    chk("beat_expected", 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    chk("o_id",  64'(bus.o_id),  64'(e.b.id));
    chk("o_ena", 64'(bus.o_ena), 64'(e.b.ena));
    chk("o_sop", 64'(bus.o_sop), 64'(e.b.sop));
    chk("o_eop", 64'(bus.o_eop), 64'(e.b.eop));
    chk("o_err", 64'(bus.o_err), 64'(e.b.err));
    chk("o_mty", 64'(bus.o_mty), 64'(e.b.mty));
    chk("o_ovf", 64'(bus.o_ovf), 64'(e.ovf));
    chk_dat("o_dat", bus.o_dat, e.b.dat, dmask(e.b));
    if (chk_lat) chk("latency", 64'(cyc - e.cyc), 64'd2);
  endtask

  // One clock: sample at the falling edge, then drive just after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    cyc++;
    acc_flag = 1'b0;
    if (stall_prev && !rst) begin
      chk("stall_ctl", 64'({bus.o_valid, bus.o_ovf, bus.o_id, bus.o_ena, bus.o_sop,
                            bus.o_eop, bus.o_err}), 64'(snap_ctl));
      chk("stall_mty", 64'(bus.o_mty), 64'(snap_mty));
      chk_dat("stall_dat", bus.o_dat, snap_dat, {DW{1'b1}});
    end
    if (rst) begin
      sb_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (bus.o_valid && bus.i_ready) pop_check();
      if (bus.i_valid && bus.o_ready) begin
        acc_flag = 1'b1;
        e = cur_exp;
        e.cyc = cyc;
        sb_q.push_back(e);
      end
      stall_prev = bus.o_valid && !bus.i_ready;
      if (stall_prev) begin
        snap_ctl = {bus.o_valid, bus.o_ovf, bus.o_id, bus.o_ena, bus.o_sop, bus.o_eop, bus.o_err};
        snap_mty = bus.o_mty;
        snap_dat = bus.o_dat;
        chk("stall_o_ready", 64'(bus.o_ready), 64'd0);
      end
    end
    @(posedge clk);
    #1;
    if (rand_rdy) bus.i_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive(input beat_t b);
    bus.i_id  = b.id;
    bus.i_ena = b.ena;
    bus.i_sop = b.sop;
    bus.i_eop = b.eop;
    bus.i_err = b.err;
    bus.i_mty = b.mty;
    bus.i_dat = b.dat;
  endtask

  task automatic send(input beat_t b, input exp_t e);
    bit got;
    got = 1'b0;
    drive(b);
    cur_exp = e;
    bus.i_valid = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      cycle();
      got = acc_flag;
    end
    if (!got) chk("send_timeout", 64'd0, 64'd1);
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    rand_rdy = 1'b0;
    bus.i_ready = 1'b1;
    for (int k = 0; k < 50 && sb_q.size() != 0; k++) cycle();
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic rand_beat(output beat_t b);
    b.id  = next_id++;
    b.ena = 12'($urandom) | 12'h90F;
    b.sop = 12'($urandom);
    b.eop = 12'($urandom) & 12'($urandom);
    b.err = 12'($urandom) & 12'($urandom) & 12'($urandom);
    b.mty = {16'($urandom), 32'($urandom)};
    for (int w = 0; w < DW / 32; w++) b.dat[w*32 +: 32] = $urandom;
  endtask

  task automatic check_zero_outputs(input string nm);
    chk({nm, "_o_valid"}, 64'(bus.o_valid), 64'd0);
    chk({nm, "_o_ovf"},   64'(bus.o_ovf),   64'd0);
    chk({nm, "_o_ctl"},   64'({bus.o_id, bus.o_ena, bus.o_sop, bus.o_eop, bus.o_err}), 64'd0);
    chk({nm, "_o_mty"},   64'(bus.o_mty),   64'd0);
    chk_dat({nm, "_o_dat"}, bus.o_dat, '0, {DW{1'b1}});
    chk({nm, "_o_ready"}, 64'(bus.o_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b, bb;
    exp_t  e, ee;

    // Hand-derived gaps and flags for each table vector.
    for (int i = 0; i < NT; i++) begin
      vt[i].ena = 12'hFFF; vt[i].sop = 12'h001; vt[i].eop = '0; vt[i].err = '0;
      vt[i].exp_err = '0; vt[i].mty = '0; vt[i].exp_ovf = 1'b0;
      vt[i].gap = '{default: 0};
    end
    vt[1].eop = 12'h004; vt[1].sop = 12'h009; vt[1].mty = m1(2, 5);
    vt[1].err = 12'h021; vt[1].exp_err = 12'h021;
    vt[1].gap = '{0, 0, 0, 5, 5, 5, 5, 5, 5, 5, 5, 5};
    vt[2].eop = 12'h112; vt[2].sop = 12'h225; vt[2].mty = m1(1, 3) | m1(4, 7) | m1(8, 15);
    vt[2].gap = '{0, 0, 3, 3, 3, 10, 10, 10, 10, 25, 25, 25};
    vt[3].eop = 12'h00F; vt[3].sop = 12'h01F;
    vt[3].mty = m1(0, 1) | m1(1, 1) | m1(2, 1) | m1(3, 1);
    vt[3].err = 12'h010; vt[3].exp_err = 12'hFFF; vt[3].exp_ovf = 1'b1;
    vt[3].gap = '{0, 1, 2, 3, 3, 3, 3, 3, 3, 3, 3, 3};
    vt[4].eop = 12'h800; vt[4].mty = 48'hFEDC_BA98_7654;
    vt[5].ena = 12'h0F7; vt[5].eop = 12'h00A; vt[5].mty = m1(1, 2) | m1(3, 6);
    vt[5].gap = '{0, 0, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
    vt[6].eop = 12'h80B; vt[6].sop = 12'h017;
    vt[6].mty = m1(0, 15) | m1(1, 15) | m1(3, 15) | m1(11, 4);
    vt[6].gap = '{0, 15, 30, 30, 45, 45, 45, 45, 45, 45, 45, 45};
    vt[7].eop = 12'h0F0; vt[7].ena = 12'hFFF; vt[7].exp_err = 12'hFFF; vt[7].exp_ovf = 1'b1;

    n_vec = 0; n_bad = 0; cyc = 0; next_id = '0;
    chk_lat = 1'b0; rand_rdy = 1'b0; stall_prev = 1'b0; acc_flag = 1'b0;
    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    bus.i_id = '0; bus.i_ena = '0; bus.i_sop = '0; bus.i_eop = '0;
    bus.i_err = '0; bus.i_mty = '0; bus.i_dat = '0;
    cur_exp = '{default: '0};

    cycle();
    cycle();
    check_zero_outputs("init_reset");
    rst = 1'b0;
    cycle();

    // Table vectors, back to back, each with a fixed two-cycle latency.
    chk_lat = 1'b1;
    for (int i = 0; i < NT; i++) begin
      b.id = next_id++;
      b.ena = vt[i].ena; b.sop = vt[i].sop; b.eop = vt[i].eop;
      b.err = vt[i].err; b.mty = vt[i].mty;
      for (int k = 0; k < NB; k++) b.dat[k*8 +: 8] = 8'(k);
      e.b = b;
      e.b.err = vt[i].exp_err;
      e.b.dat = shift_dat(b.dat, vt[i].gap);
      e.ovf = vt[i].exp_ovf;
      e.cyc = 0;
      send(b, e);
    end
    drain();

    // Stall: two beats fill the pipe, a third is held off while i_ready is low.
    chk_lat = 1'b0;
    bus.i_ready = 1'b0;
    rand_beat(b); model(b, e); send(b, e);
    rand_beat(b); model(b, e); send(b, e);
    rand_beat(bb); model(bb, ee);
    drive(bb);
    cur_exp = ee;
    bus.i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("held_o_ready", 64'(bus.o_ready), 64'd0);
      chk("held_o_valid", 64'(bus.o_valid), 64'd1);
    end
    bus.i_ready = 1'b1;
    send(bb, ee);
    drain();

    // Reset with two beats in flight and a beat offered during reset.
    rand_beat(b); model(b, e); send(b, e);
    rand_beat(b); model(b, e); send(b, e);
    rst = 1'b1;
    bus.i_ready = 1'b0;
    rand_beat(b); model(b, e);
    drive(b);
    cur_exp = e;
    bus.i_valid = 1'b1;
    #1;
    chk("rst_o_ready", 64'(bus.o_ready), 64'd1);
    cycle();
    check_zero_outputs("rst1");
    cycle();
    check_zero_outputs("rst2");
    rst = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("post_rst_o_valid", 64'(bus.o_valid), 64'd0);
    end
    chk_lat = 1'b1;
    rand_beat(b); model(b, e); send(b, e);
    drain();

    // Random traffic with 50% downstream backpressure and input bubbles.
    chk_lat = 1'b0;
    rand_rdy = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) cycle();
      rand_beat(b);
      model(b, e);
      send(b, e);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
